// File: rtl/mesi_pkg.sv
// -----------------------------------------------------------------------------
// mesi_pkg
// Shared encodings for the per-line MESI coherence controller: line states,
// local processor actions, snooped/broadcast bus messages and the packed
// result bundle produced each evaluation.
// Configuration macro: MESI_EXCLUSIVE_EN (full MESI when defined, MSI otherwise).
// -----------------------------------------------------------------------------
package mesi_pkg;

  typedef enum logic [1:0] {
    ST_I = 2'b00,
    ST_S = 2'b01,
    ST_E = 2'b10,
    ST_M = 2'b11
  } mesi_state_e;

  typedef enum logic [1:0] {
    ACT_RD_MISS = 2'b00,
    ACT_RD_HIT  = 2'b01,
    ACT_WR_MISS = 2'b10,
    ACT_WR_HIT  = 2'b11
  } mesi_act_e;

  typedef enum logic [1:0] {
    BUS_NONE   = 2'b00,
    BUS_RDMISS = 2'b01,
    BUS_WRMISS = 2'b10,
    BUS_INV    = 2'b11
  } mesi_bus_e;

  // One evaluation's results, in output order {est_fut, bus_out, mem_out}.
  typedef struct packed {
    mesi_state_e est;
    mesi_bus_e   bus;
    logic        mem;
  } mesi_result_t;

  // When clear, a read miss always fills in S and E is never produced.
`ifdef MESI_EXCLUSIVE_EN
  localparam bit EXCLUSIVE_EN = 1'b1;
`else
  localparam bit EXCLUSIVE_EN = 1'b0;
`endif

endpackage

// File: rtl/mesi_fsm_if.sv
// -----------------------------------------------------------------------------
// mesi_fsm_if
// Groups the evaluation inputs and registered results of mesi_fsm.
//   op      : {cpu_side, acao[1:0], shared}
//   bus_in  : snooped bus message
//   estado  : current line state
//   bus_out : message to broadcast
//   mem_out : write-back strobe
//   est_fut : next line state
// master = owning cache side, slave = mesi_fsm.
// -----------------------------------------------------------------------------
interface mesi_fsm_if;
  logic [3:0] op;
  logic [1:0] bus_in;
  logic [1:0] estado;
  logic [1:0] bus_out;
  logic       mem_out;
  logic [1:0] est_fut;

  modport master (output op, bus_in, estado, input  bus_out, mem_out, est_fut);
  modport slave  (input  op, bus_in, estado, output bus_out, mem_out, est_fut);
endinterface

// File: rtl/mesi_next_state.sv
// -----------------------------------------------------------------------------
// mesi_next_state
// Purely combinational MESI transition function for one cache line.
//   op_i     in  4 : {cpu_side, acao[1:0], shared}
//   bus_in_i in  2 : snooped bus message
//   estado_i in  2 : current line state
//   res_o    out 5 : {next state, bus message, write-back strobe}
// Configuration macro: MESI_EXCLUSIVE_EN (via mesi_pkg::EXCLUSIVE_EN).
// -----------------------------------------------------------------------------
module mesi_next_state
  import mesi_pkg::*;
(
  input  logic [3:0]   op_i,
  input  logic [1:0]   bus_in_i,
  input  logic [1:0]   estado_i,
  output mesi_result_t res_o
);

  mesi_state_e st;
  mesi_act_e   act;

  // NOTE: every output gets a default before any branch, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    st        = mesi_state_e'(estado_i);
    act       = mesi_act_e'(op_i[2:1]);
    res_o.est = st;
    res_o.bus = BUS_NONE;
    res_o.mem = 1'b0;

    if (op_i[3]) begin
      // A "hit" on an invalid line is really a miss.
      if (st == ST_I && act == ACT_RD_HIT) act = ACT_RD_MISS;
      if (st == ST_I && act == ACT_WR_HIT) act = ACT_WR_MISS;

      case (act)
        ACT_RD_HIT: ;  // state unchanged, silent
        ACT_RD_MISS: begin
          res_o.bus = BUS_RDMISS;
          res_o.mem = (st == ST_M);  // dirty victim write-back
          res_o.est = (op_i[0] || !EXCLUSIVE_EN) ? ST_S : ST_E;
        end
        ACT_WR_HIT: begin
          res_o.est = ST_M;
          if (st == ST_S) res_o.bus = BUS_INV;  // other sharers must drop it
        end
        ACT_WR_MISS: begin
          res_o.bus = BUS_WRMISS;
          res_o.mem = (st == ST_M);
          res_o.est = ST_M;
        end
        default: ;
      endcase
    end else begin
      // Snoop: never broadcasts; the owner of a dirty line supplies it.
      case (mesi_bus_e'(bus_in_i))
        BUS_NONE: ;
        BUS_RDMISS: begin
          res_o.mem = (st == ST_M);
          if (st == ST_M || st == ST_E) res_o.est = ST_S;
        end
        BUS_WRMISS, BUS_INV: begin
          res_o.mem = (st == ST_M);
          res_o.est = ST_I;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mesi_fsm.sv
// -----------------------------------------------------------------------------
// mesi_fsm
// Per-line MESI coherence controller. Evaluates one local access or snooped
// message per clock and registers {est_fut, bus_out, mem_out}; latency 1.
//   clock in 1 : rising-edge clock
//   clear in 1 : synchronous active-low reset (outputs -> I / none / 0)
//   port       : mesi_fsm_if.slave (op, bus_in, estado -> bus_out, mem_out, est_fut)
// Configuration macro: MESI_EXCLUSIVE_EN (full MESI when defined, MSI otherwise).
// -----------------------------------------------------------------------------
module mesi_fsm
  import mesi_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  mesi_fsm_if.slave   port
);

  mesi_result_t res_d, res_q;

  mesi_next_state u_next_state (
    .op_i     (port.op),
    .bus_in_i (port.bus_in),
    .estado_i (port.estado),
    .res_o    (res_d)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (!clear) res_q <= '0;
    else        res_q <= res_d;
  end

  assign port.est_fut = res_q.est;
  assign port.bus_out = res_q.bus;
  assign port.mem_out = res_q.mem;

endmodule

// File: tb/tb_mesi_fsm.sv
// -----------------------------------------------------------------------------
// tb_mesi_fsm
// Self-checking bench for mesi_fsm: directed vectors followed by random ones,
// each compared against a rule-level reference model.
// Honours MESI_EXCLUSIVE_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_mesi_fsm;

`ifdef MESI_EXCLUSIVE_EN
  localparam bit EXCL = 1'b1;
`else
  localparam bit EXCL = 1'b0;
`endif

  logic clock;
  logic clear;
  int   n_vec  = 0;
  int   n_fail = 0;

  mesi_fsm_if dut_if ();

  mesi_fsm dut (
    .clock (clock),
    .clear (clear),
    .port  (dut_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Rule-level model: returns {next_state, bus_msg, write_back}.
  function automatic logic [4:0] model(bit clr, logic [3:0] op,
                                       logic [1:0] bin, logic [1:0] st);
    int  nxt, msg;
    bit  wb, is_write, is_hit, dirty;
    if (!clr) return 5'b0;
    dirty = (st == 2'd3);
    if (op[3]) begin
      is_write = op[2];
      is_hit   = op[1] && (st != 2'd0);
      if (!is_write && is_hit) begin
        nxt = st; msg = 0; wb = 0;
      end else if (!is_write) begin
        msg = 1; wb = dirty;
        nxt = (op[0] || !EXCL) ? 1 : 2;
      end else if (is_hit) begin
        nxt = 3; wb = 0;
        msg = (st == 2'd1) ? 3 : 0;
      end else begin
        nxt = 3; msg = 2; wb = dirty;
      end
    end else begin
      msg = 0;
      wb  = dirty && (bin != 2'd0);
      if (bin == 2'd0)      nxt = st;
      else if (bin == 2'd1) nxt = (st >= 2'd2) ? 1 : st;
      else                  nxt = 0;
    end
    return {nxt[1:0], msg[1:0], wb};
  endfunction

  task automatic check(string tag, logic [4:0] got, logic [4:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got est/bus/mem=%b/%b/%b expected %b/%b/%b",
               tag, got[4:3], got[2:1], got[0], exp[4:3], exp[2:1], exp[0]);
    end
  endtask

  // Drive inputs just after an edge, sample 1 time unit after the next edge.
  task automatic apply(string tag, bit clr, logic [3:0] op,
                       logic [1:0] bin, logic [1:0] st);
    clear         = clr;
    dut_if.op     = op;
    dut_if.bus_in = bin;
    dut_if.estado = st;
    @(posedge clock);
    #1;
    check(tag, {dut_if.est_fut, dut_if.bus_out, dut_if.mem_out},
          model(clr, op, bin, st));
  endtask

  initial begin
    clear         = 1'b0;
    dut_if.op     = 4'b0;
    dut_if.bus_in = 2'b0;
    dut_if.estado = 2'b0;
    @(posedge clock);
    #1;

    // Reset with busy inputs, and a reset between two dirty evaluations.
    apply("reset_busy",     1'b0, 4'b1100, 2'b11, 2'b11);
    apply("rdmiss_I_excl",  1'b1, 4'b1000, 2'b00, 2'b00);
    apply("reset_override", 1'b0, 4'b1100, 2'b00, 2'b11);
    apply("rdmiss_I_shr",   1'b1, 4'b1001, 2'b00, 2'b00);
    apply("rdhit_I",        1'b1, 4'b1010, 2'b11, 2'b00);
    apply("rdhit_E",        1'b1, 4'b1010, 2'b00, 2'b10);
    apply("rdmiss_M_vict",  1'b1, 4'b1001, 2'b00, 2'b11);
    apply("wrhit_S",        1'b1, 4'b1110, 2'b00, 2'b01);
    apply("wrhit_E",        1'b1, 4'b1110, 2'b00, 2'b10);
    apply("wrhit_I",        1'b1, 4'b1111, 2'b00, 2'b00);
    apply("wrmiss_M",       1'b1, 4'b1100, 2'b00, 2'b11);
    apply("wrmiss_M_again", 1'b1, 4'b1100, 2'b00, 2'b11);
    apply("snp_rd_M",       1'b1, 4'b0000, 2'b01, 2'b11);
    apply("snp_rd_E",       1'b1, 4'b0111, 2'b01, 2'b10);
    apply("snp_rd_S",       1'b1, 4'b0000, 2'b01, 2'b01);
    apply("snp_inv_S",      1'b1, 4'b0000, 2'b11, 2'b01);
    apply("snp_wr_S",       1'b1, 4'b0000, 2'b10, 2'b01);
    apply("snp_inv_M",      1'b1, 4'b0101, 2'b11, 2'b11);
    apply("snp_none_M",     1'b1, 4'b0000, 2'b00, 2'b11);

    for (int i = 0; i < 600; i++) begin
      apply("random",
            ($urandom_range(0, 15) != 0),
            4'($urandom_range(0, 15)),
            2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
